compress_packer: RTL and testbench

Re-encodes a stream of 32-bit RV32I instructions into RVC form wherever a legal 16-bit encoding exists, and packs the resulting 16/32-bit parcels into little-endian 32-bit words. It is the inverse of the cache-side decompressor. It sits on the tooling and verification path, where it builds compressed instruction-ROM images and drives round-trip self-checks (`decompress(compress(x)) == x`). Branch and jump offsets are encoded verbatim and are never relocated.

---
 rtl/compress_packer.sv | 220 ++++++++++++++++++++++
 tb/tb_compress_packer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compress_packer.sv
// rtl/compress_packer.sv - RV32I to RVC re-encoder with 16/32-bit parcel packer
//
// Purpose: compresses each accepted 32-bit RV32I instruction into a 16-bit RVC
// parcel where a legal encoding exists, and packs the resulting parcels into
// little-endian 32-bit words (out_word[15:0] holds the earlier parcel).
// Branch and jump offsets are copied verbatim, never relocated.
//
// Ports:
//   clk_in, rst_in          clock, synchronous active-high reset
//   in_valid/in_ready       instruction handshake, in_instr is the instruction
//   flush_in                pad a pending halfword with C.NOP and emit it
//   out_valid/out_ready     packed word handshake, out_word is the word
//   stat_in_cnt             instructions accepted (wraps)
//   stat_c_cnt              instructions emitted in compressed form (wraps)
//
// Build option: COMPRESS_BRANCH_EN enables the C.J/C.JAL/C.BEQZ/C.BNEZ rules;
// without it jal/beq/bne always pass through as 32 bits.

module compress_packer #(
  parameter int CNT_W = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             flush_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_word,
  output logic [CNT_W-1:0] stat_in_cnt,
  output logic [CNT_W-1:0] stat_c_cnt
);

  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_REG  = 7'b0110011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;

  logic [6:0]  op, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [11:0] ii, si;
  logic        rdp, rs1p, rs2p, imm6_ok, lui_ok;

  assign op   = in_instr[6:0];
  assign rd   = in_instr[11:7];
  assign f3   = in_instr[14:12];
  assign rs1  = in_instr[19:15];
  assign rs2  = in_instr[24:20];
  assign f7   = in_instr[31:25];
  assign ii   = in_instr[31:20];
  assign si   = {in_instr[31:25], in_instr[11:7]};
  // x8..x15 are the only registers reachable by the 3-bit RVC fields
  assign rdp  = (rd[4:3] == 2'b01);
  assign rs1p = (rs1[4:3] == 2'b01);
  assign rs2p = (rs2[4:3] == 2'b01);
  assign imm6_ok = (ii[11:5] == 7'h00) || (ii[11:5] == 7'h7f);
  assign lui_ok  = (in_instr[31:17] == 15'h0000) || (in_instr[31:17] == 15'h7fff);

  // Register-register ALU ops that have a C.SUB/XOR/OR/AND form
  logic       alu_hit;
  logic [1:0] alu_f2;
  always_comb begin
    alu_hit = 1'b1;
    alu_f2  = 2'b00;
    case ({f7, f3})
      {7'h20, 3'b000}: alu_f2 = 2'b00;
      {7'h00, 3'b100}: alu_f2 = 2'b01;
      {7'h00, 3'b110}: alu_f2 = 2'b10;
      {7'h00, 3'b111}: alu_f2 = 2'b11;
      default:         alu_hit = 1'b0;
    endcase
  end

  logic        br_ok;
  logic [15:0] br_par;
`ifdef COMPRESS_BRANCH_EN
  logic [20:1] ji;
  logic [12:1] bi;
  assign ji = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21]};
  assign bi = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8]};
  always_comb begin
    br_ok  = 1'b0;
    br_par = 16'h0;
    if (op == 7'b1101111 && rd[4:1] == 4'd0 &&
        (ji[20:11] == 10'h000 || ji[20:11] == 10'h3ff)) begin
      br_ok  = 1'b1;
      br_par = {~rd[0], 2'b01, ji[11], ji[4], ji[9:8], ji[10], ji[6], ji[7], ji[3:1], ji[5], 2'b01};
    end else if (op == 7'b1100011 && f3[2:1] == 2'b00 && rs2 == 5'd0 && rs1p &&
                 (bi[12:8] == 5'h00 || bi[12:8] == 5'h1f)) begin
      br_ok  = 1'b1;
      br_par = {2'b11, f3[0], bi[8], bi[4:3], rs1[2:0], bi[7:6], bi[2:1], bi[5], 2'b01};
    end
  end
`else
  assign br_ok  = 1'b0;
  assign br_par = 16'h0;
`endif

  // Compressor: first matching rule wins
  logic        c_ok;
  logic [15:0] c_par;
  always_comb begin
    c_ok  = 1'b1;
    c_par = 16'h0;
    if (in_instr == 32'h0000_0013) begin
      c_par = 16'h0001;
    end else if (op == OP_IMM && f3 == 3'b000 && rs1 == 5'd2 && rdp &&
                 ii[11:10] == 2'b00 && ii[1:0] == 2'b00 && ii != 12'd0) begin
      c_par = {3'b000, ii[5:4], ii[9:6], ii[2], ii[3], rd[2:0], 2'b00};
    end else if (op == OP_IMM && f3 == 3'b000 && rd == 5'd2 && rs1 == 5'd2 &&
                 ii[3:0] == 4'd0 && (ii[11:9] == 3'b000 || ii[11:9] == 3'b111) && ii != 12'd0) begin
      c_par = {3'b011, ii[9], 5'd2, ii[4], ii[6], ii[8:7], ii[5], 2'b01};
    end else if (op == OP_IMM && f3 == 3'b000 && rs1 == 5'd0 && rd != 5'd0 && imm6_ok) begin
      c_par = {3'b010, ii[5], rd, ii[4:0], 2'b01};
    end else if (op == OP_IMM && f3 == 3'b000 && rd == rs1 && rd != 5'd0 && ii != 12'd0 && imm6_ok) begin
      c_par = {3'b000, ii[5], rd, ii[4:0], 2'b01};
    end else if (op == OP_LUI && rd != 5'd0 && rd != 5'd2 && in_instr[31:12] != 20'd0 && lui_ok) begin
      c_par = {3'b011, in_instr[17], rd, in_instr[16:12], 2'b01};
    end else if (op == OP_IMM && f3 == 3'b001 && f7 == 7'h00 && rd == rs1 && rd != 5'd0 && rs2 != 5'd0) begin
      c_par = {3'b000, 1'b0, rd, rs2, 2'b10};
    end else if (op == OP_IMM && f3 == 3'b101 && (f7 == 7'h00 || f7 == 7'h20) &&
                 rd == rs1 && rdp && rs2 != 5'd0) begin
      c_par = {3'b100, 1'b0, 1'b0, f7[5], rd[2:0], rs2, 2'b01};
    end else if (op == OP_IMM && f3 == 3'b111 && rd == rs1 && rdp && imm6_ok) begin
      c_par = {3'b100, ii[5], 2'b10, rd[2:0], ii[4:0], 2'b01};
    end else if (op == OP_REG && alu_hit && rd == rs1 && rdp && rs2p) begin
      c_par = {3'b100, 1'b0, 2'b11, rd[2:0], alu_f2, rs2[2:0], 2'b01};
    end else if (op == OP_REG && f3 == 3'b000 && f7 == 7'h00 && rs1 == 5'd0 && rd != 5'd0 && rs2 != 5'd0) begin
      c_par = {4'b1000, rd, rs2, 2'b10};
    end else if (op == OP_REG && f3 == 3'b000 && f7 == 7'h00 && rd == rs1 && rd != 5'd0 && rs2 != 5'd0) begin
      c_par = {4'b1001, rd, rs2, 2'b10};
    end else if (op == OP_JALR && f3 == 3'b000 && ii == 12'd0 && rd[4:1] == 4'd0 && rs1 != 5'd0) begin
      c_par = {3'b100, rd[0], rs1, 5'd0, 2'b10};
    end else if (op == OP_LD && f3 == 3'b010 && rs1p && rdp && ii[11:7] == 5'd0 && ii[1:0] == 2'b00) begin
      c_par = {3'b010, ii[5:3], rs1[2:0], ii[2], ii[6], rd[2:0], 2'b00};
    end else if (op == OP_ST && f3 == 3'b010 && rs1p && rs2p && si[11:7] == 5'd0 && si[1:0] == 2'b00) begin
      c_par = {3'b110, si[5:3], rs1[2:0], si[2], si[6], rs2[2:0], 2'b00};
    end else if (op == OP_LD && f3 == 3'b010 && rs1 == 5'd2 && rd != 5'd0 &&
                 ii[11:8] == 4'd0 && ii[1:0] == 2'b00) begin
      c_par = {3'b010, ii[5], rd, ii[4:2], ii[7:6], 2'b10};
    end else if (op == OP_ST && f3 == 3'b010 && rs1 == 5'd2 && si[11:8] == 4'd0 && si[1:0] == 2'b00) begin
      c_par = {3'b110, si[5:2], si[7:6], rs2, 2'b10};
    end else if (br_ok) begin
      c_par = br_par;
    end else begin
      c_ok = 1'b0;
    end
  end

  // Packer
  logic        hold_v;
  logic [15:0] hold;
  logic        accept, emit_v, nxt_hold_v;
  logic [31:0] emit_w;
  logic [15:0] nxt_hold;

  // Ready is forced during reset so upstream never sees a stall across it
  assign in_ready = rst_in | ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    emit_v     = 1'b0;
    emit_w     = 32'h0;
    nxt_hold   = hold;
    nxt_hold_v = hold_v;
    if (accept) begin
      if (!hold_v) begin
        if (c_ok) begin
          nxt_hold   = c_par;
          nxt_hold_v = 1'b1;
        end else begin
          emit_v = 1'b1;
          emit_w = in_instr;
        end
      end else if (c_ok) begin
        emit_v     = 1'b1;
        emit_w     = {c_par, hold};
        nxt_hold_v = 1'b0;
      end else begin
        // 32-bit instruction straddles: low half completes this word
        emit_v   = 1'b1;
        emit_w   = {in_instr[15:0], hold};
        nxt_hold = in_instr[31:16];
      end
    end else if (flush_in && !in_valid && in_ready && hold_v) begin
      emit_v     = 1'b1;
      emit_w     = {16'h0001, hold};
      nxt_hold_v = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hold_v      <= 1'b0;
      hold        <= 16'h0;
      out_valid   <= 1'b0;
      out_word    <= 32'h0;
      stat_in_cnt <= '0;
      stat_c_cnt  <= '0;
    end else begin
      hold_v <= nxt_hold_v;
      hold   <= nxt_hold;
      if (emit_v) begin
        out_valid <= 1'b1;
        out_word  <= emit_w;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        stat_in_cnt <= stat_in_cnt + CNT_W'(1);
        if (c_ok) stat_c_cnt <= stat_c_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_compress_packer.sv
// tb/tb_compress_packer.sv - self-checking bench for compress_packer

module tb_compress_packer;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'h0;
  logic        flush_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_word;
  logic [31:0] stat_in_cnt, stat_c_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit rnd_mode = 1'b0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  compress_packer #(.CNT_W(32)) dut (
    .clk_in(clk), .rst_in(rst_in), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flush_in(flush_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_word(out_word), .stat_in_cnt(stat_in_cnt),
    .stat_c_cnt(stat_c_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard: every completed output handshake is checked against exp_q
  always @(negedge clk) begin
    if (!rst_in && out_valid && out_ready) begin
      if (rnd_mode) begin
        obs_q.push_back(out_word);
      end else begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got %h, required no word", out_word);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (out_word !== e) begin
            n_fail++;
            $display("FAIL sb_word: got %h, required %h", out_word, e);
          end
        end
      end
    end
  end

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_r(logic [4:0] rs2, logic [4:0] rs1, logic [4:0] rd);
    return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  // Reference decompressor for the RVC forms the random stream can produce
  function automatic logic [32:0] decomp(logic [15:0] h);
    logic [31:0] r;
    logic        ok;
    ok = 1'b1;
    r  = 32'h0;
    case ({h[1:0], h[15:13]})
      5'b00_000: r = enc_i({2'b00, h[10:7], h[12:11], h[5], h[6], 2'b00}, 5'd2, 3'b000, {2'b01, h[4:2]}, 7'h13);
      5'b00_010: r = enc_i({5'b0, h[5], h[12:10], h[6], 2'b00}, {2'b01, h[9:7]}, 3'b010, {2'b01, h[4:2]}, 7'h03);
      5'b00_110: r = enc_s({5'b0, h[5], h[12:10], h[6], 2'b00}, {2'b01, h[4:2]}, {2'b01, h[9:7]});
      5'b01_000: r = enc_i({{7{h[12]}}, h[6:2]}, h[11:7], 3'b000, h[11:7], 7'h13);
      5'b01_010: r = enc_i({{7{h[12]}}, h[6:2]}, 5'd0, 3'b000, h[11:7], 7'h13);
      5'b01_011: begin
        if (h[11:7] == 5'd2)
          r = enc_i({{3{h[12]}}, h[4:3], h[5], h[2], h[6], 4'b0}, 5'd2, 3'b000, 5'd2, 7'h13);
        else
          ok = 1'b0;
      end
      5'b10_010: r = enc_i({4'b0, h[3:2], h[12], h[6:4], 2'b00}, 5'd2, 3'b010, h[11:7], 7'h03);
      5'b10_110: r = enc_s({4'b0, h[8:7], h[12:9], 2'b00}, h[6:2], 5'd2);
      5'b10_100: begin
        if (h[6:2] != 5'd0) r = enc_r(h[6:2], h[12] ? h[11:7] : 5'd0, h[11:7]);
        else ok = 1'b0;
      end
      default: ok = 1'b0;
    endcase
    return {ok, r};
  endfunction

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0:       return 5'd2;
      1:       return 5'(8 + $urandom_range(0, 7));
      2:       return 5'd0;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic do_reset();
    rst_in = 1'b1; in_valid = 1'b0; flush_in = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_in = 1'b0;
  endtask

  task automatic send(input logic [31:0] w);
    int t = 0;
    in_valid = 1'b1;
    in_instr = w;
    @(negedge clk);
    while (!in_ready && t < 100) begin t++; @(negedge clk); end
    if (t >= 100) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic flush();
    flush_in = 1'b1;
    @(posedge clk);
    #1 flush_in = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 50) begin t++; @(posedge clk); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_missing: %0d words outstanding, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_in = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_during: got %b, required 1", in_ready); end
    @(posedge clk); #1 rst_in = 1'b0;
    n_checks += 5;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    if (out_word !== 32'h0) begin n_fail++; $display("FAIL reset_out_word: got %h, required 0", out_word); end
    if (stat_in_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_in_cnt: got %0d, required 0", stat_in_cnt); end
    if (stat_c_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_c_cnt: got %0d, required 0", stat_c_cnt); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_after: got %b, required 1", in_ready); end
  endtask

  task automatic test_hold_pair();
    do_reset();
    exp_q.push_back(32'h952E4515);
    send(32'h00500513);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pair_first_no_out: got %b, required 0", out_valid); end
    send(32'h00B50533);
    n_checks += 2;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pair_latency_valid: got %b, required 1", out_valid); end
    if (out_word !== 32'h952E4515) begin n_fail++; $display("FAIL pair_latency_word: got %h, required 952e4515", out_word); end
    drain();
    n_checks++;
    if (stat_c_cnt !== 32'd2) begin n_fail++; $display("FAIL pair_c_cnt: got %0d, required 2", stat_c_cnt); end
  endtask

  task automatic test_straddle_flush();
    do_reset();
    exp_q.push_back(32'h02934515);
    exp_q.push_back(32'h00010013);
    send(32'h00500513);
    send(32'h00130293);
    flush();
    drain();
    n_checks += 2;
    if (stat_in_cnt !== 32'd2) begin n_fail++; $display("FAIL straddle_in_cnt: got %0d, required 2", stat_in_cnt); end
    if (stat_c_cnt !== 32'd1) begin n_fail++; $display("FAIL straddle_c_cnt: got %0d, required 1", stat_c_cnt); end
  endtask

  // Each instruction is followed by a flush, so a 16-bit result shows up as {C.NOP, c}
  task automatic test_compress_table();
    logic [31:0] ti [18];
    logic [31:0] te [18];
    ti = '{32'h00000013, 32'h01010413, 32'hFF010113, 32'h00500513, 32'hFFF50513, 32'h000017B7,
           32'h00B50533, 32'h00442483, 32'h00112423, 32'h00008067, 32'h00130293, 32'h00351513,
           32'h40940433, 32'h00100013, 32'h40010413, 32'h02000513, 32'hFE000513, 32'h08042483};
    te = '{32'h00010001, 32'h00010800, 32'h0001717D, 32'h00014515, 32'h0001157D, 32'h00016785,
           32'h0001952E, 32'h00014044, 32'h0001C406, 32'h00018082, 32'h00130293, 32'h0001050E,
           32'h00018C05, 32'h00100013, 32'h40010413, 32'h02000513, 32'h00015501, 32'h08042483};
    do_reset();
    for (int i = 0; i < 18; i++) begin
      exp_q.push_back(te[i]);
      send(ti[i]);
      flush();
    end
    drain();
    n_checks++;
    if (stat_c_cnt !== 32'd13) begin n_fail++; $display("FAIL table_c_cnt: got %0d, required 13", stat_c_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    exp_q.push_back(32'h00130293);
    exp_q.push_back(32'h00238313);
    send(32'h00130293);
    in_valid = 1'b1;
    in_instr = 32'h00238313;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks += 3;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b, required 0", in_ready); end
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid: got %b, required 1", out_valid); end
      if (out_word !== 32'h00130293) begin n_fail++; $display("FAIL bp_out_word: got %h, required 00130293", out_word); end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b, required 1", in_ready); end
    @(posedge clk); #1 in_valid = 1'b0;
    n_checks += 3;
    if (stat_in_cnt !== 32'd2) begin n_fail++; $display("FAIL bp_same_cycle_accept: got %0d, required 2", stat_in_cnt); end
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_reload_valid: got %b, required 1", out_valid); end
    if (out_word !== 32'h00238313) begin n_fail++; $display("FAIL bp_reload_word: got %h, required 00238313", out_word); end
    drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(32'h00500513);
    rst_in = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %b, required 1", in_ready); end
    @(posedge clk); #1 rst_in = 1'b0;
    flush();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_no_out: got %b, required 0", out_valid); end
    end
    n_checks += 2;
    if (stat_in_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_reset_in_cnt: got %0d, required 0", stat_in_cnt); end
    if (stat_c_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_reset_c_cnt: got %0d, required 0", stat_c_cnt); end
    drain();
  endtask

  task automatic test_branch();
    do_reset();
`ifdef COMPRESS_BRANCH_EN
    exp_q.push_back(32'hC401C401);
`else
    exp_q.push_back(32'h00040463);
    exp_q.push_back(32'h00040463);
`endif
    send(32'h00040463);
    send(32'h00040463);
    drain();
  endtask

  task automatic test_random_stream();
    logic [31:0] in_q[$];
    logic [15:0] hq[$];
    logic [32:0] d;
    logic [31:0] w, got, e;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    int          n16, i, r;
    bit          ok;
    do_reset();
    rnd_mode = 1'b1;
    obs_q.delete();
    for (int k = 0; k < 300; k++) begin
      rd = 5'($urandom_range(1, 31));
      case ($urandom_range(0, 3))
        0: begin
          rs1 = $urandom_range(0, 1) ? rd : pick_reg();
          r   = int'($urandom_range(0, 63));
          case ($urandom_range(0, 3))
            0:       imm = 12'(r - 32);
            1:       imm = 12'(r * 16);
            2:       imm = 12'((r - 32) * 16);
            default: imm = 12'($urandom);
          endcase
          w = enc_i(imm, rs1, 3'b000, rd, 7'h13);
        end
        1: begin
          r   = int'($urandom_range(0, 2));
          rs1 = (r == 0) ? 5'd0 : (r == 1) ? rd : pick_reg();
          w   = enc_r(pick_reg(), rs1, rd);
        end
        2: begin
          if ($urandom_range(0, 1) != 0) rd = 5'(8 + $urandom_range(0, 7));
          imm = $urandom_range(0, 1) ? 12'($urandom_range(0, 63) * 4) : 12'($urandom);
          w   = enc_i(imm, pick_reg(), 3'b010, rd, 7'h03);
        end
        default: begin
          imm = $urandom_range(0, 1) ? 12'($urandom_range(0, 63) * 4) : 12'($urandom);
          w   = enc_s(imm, pick_reg(), pick_reg());
        end
      endcase
      in_q.push_back(w);
      if ($urandom_range(0, 3) == 0) begin
        out_ready = 1'b0;
        @(posedge clk); #1 out_ready = 1'b1;
      end
      send(w);
    end
    flush();
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (dut.hold_v !== 1'b0) begin n_fail++; $display("FAIL rnd_flush_hold_v: got %b, required 0", dut.hold_v); end
    n_checks++;
    if (stat_in_cnt !== 32'd300) begin n_fail++; $display("FAIL rnd_in_cnt: got %0d, required 300", stat_in_cnt); end
    foreach (obs_q[j]) begin
      hq.push_back(obs_q[j][15:0]);
      hq.push_back(obs_q[j][31:16]);
    end
    n16 = 0;
    i = 0;
    while (i < hq.size()) begin
      if (hq[i][1:0] == 2'b11) begin
        ok  = (i + 1 < hq.size());
        got = ok ? {hq[i+1], hq[i]} : 32'h0;
        i += 2;
      end else if (in_q.size() == 0 && hq[i] == 16'h0001) begin
        i += 1;
        continue;
      end else begin
        d   = decomp(hq[i]);
        ok  = d[32];
        got = d[31:0];
        n16++;
        i += 1;
      end
      n_checks++;
      if (in_q.size() == 0) begin
        n_fail++;
        $display("FAIL rnd_extra_parcel: got %h, required none", got);
      end else begin
        e = in_q.pop_front();
        if (!ok || got !== e) begin
          n_fail++;
          $display("FAIL rnd_roundtrip: got %h (decodable %b), required %h", got, ok, e);
        end
      end
    end
    n_checks += 2;
    if (in_q.size() != 0) begin n_fail++; $display("FAIL rnd_missing: %0d instructions unreproduced, required 0", in_q.size()); end
    if (stat_c_cnt !== 32'(n16)) begin n_fail++; $display("FAIL rnd_c_cnt: got %0d, required %0d", stat_c_cnt, n16); end
    rnd_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hold_pair();
    test_straddle_flush();
    test_compress_table();
    test_backpressure();
    test_reset_mid();
    test_branch();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
